data_mem_unit: RTL

- Data-memory stage that sits directly on the RV32I core's dm* bus and returns load data one cycle after the address is presented.
- Provides byte-addressable RAM with func3-based sub-word load/store: sign or zero extension on loads, byte lanes on stores.
- Detects misaligned and illegal accesses.
- Adds a small MMIO block: console TX FIFO with valid/ready drain, status register, optional cycle counter.

---
 rtl/data_mem_unit_pkg.sv | 59 +++++
 rtl/data_mem_unit_if.sv | 15 +
 rtl/data_mem_unit_byte_fifo.sv | 64 ++++++
 rtl/data_mem_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/data_mem_unit_pkg.sv
// Shared encodings for the data-memory stage: func3 codes, MMIO offsets, STATUS bits,
// and the load-formatting helpers used on the read path.
package data_mem_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CYCLES = 4'h8;

  localparam int unsigned ST_NOT_FULL  = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_COUNT_LSB = 8;
  localparam int unsigned ST_ERR       = 16;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_RAM  = 2'd1,
    REG_IO   = 2'd2
  } region_e;

  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3 == 3'd3) || (f3 >= 3'd6);
  endfunction

  // Store encodings share the load codes, so one check covers both directions.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_LH, F3_LHU: return lo[0];
      F3_LW:         return lo != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_format(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LBU:  return {24'h0, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LHU:  return {16'h0, h};
      F3_LW:   return word;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Core-side dm* bus between the RV32I pipeline (master) and the data-memory stage (slave).
interface data_mem_unit_if;
  import data_mem_unit_pkg::*;

  logic [31:0] dmAddress;
  logic [2:0]  dmFunc3;
  logic        dmWrite;
  logic [31:0] dmDataOut;
  logic [31:0] dmDataIn;

  modport master (output dmAddress, output dmFunc3, output dmWrite, output dmDataOut,
                  input  dmDataIn);
  modport slave  (input  dmAddress, input  dmFunc3, input  dmWrite, input  dmDataOut,
                  output dmDataIn);
endinterface

// File: rtl/data_mem_unit_byte_fifo.sv
// Byte FIFO for the console TX path; the head is registered, so a byte pushed into an
// empty FIFO reaches head_o/valid_o one clock after the push edge.
module byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [7:0]             push_data_i,
  input  logic                   ready_i,
  output logic [7:0]             head_o,
  output logic                   valid_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    head_q, head_d;
  logic          valid_q, valid_d;
  logic          pop, push_ok;

  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign head_o  = head_q;
  assign valid_o = valid_q;

  // Head only advances onto entries that existed before this edge.
  always_comb begin : next_state
    pop      = valid_q && ready_i;
    push_ok  = push_i && (!full_o || pop);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    valid_d  = count_q > CW'(pop);
    head_d   = valid_d ? mem_q[rd_ptr_d] : head_q;
  end

  always_ff @(posedge clock) begin : storage
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clock or posedge reset) begin : state_reg
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory stage on the RV32I dm* bus: byte-addressable RAM with sub-word access plus
// an MMIO block (TX FIFO, STATUS). Define DMEM_CYCLE_COUNTER_EN for the CYCLES register.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 12,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic           clock,
  input  logic           reset,
  data_mem_unit_if.slave dm_bus,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic           access_err
);
  localparam int unsigned WORDS = 2 ** (ADDR_BITS - 2);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]          addr, wr_data_in;
  logic [2:0]           f3;
  logic                 is_ram, is_io, bad, ram_we, io_push, err_clr;
  logic [3:0]           io_off, be;
  logic [31:0]          wdata, status, io_rdata_d, io_rdata_q, load_data_c;
  logic [ADDR_BITS-3:0] widx;
  logic [31:0]          ram [WORDS];
  logic [31:0]          ram_rd_q;
  region_e              region_d, region_q;
  logic [2:0]           f3_q;
  logic [1:0]           lo_q;
  logic                 err_d, err_q;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [3:0]           occ4;

  assign addr       = dm_bus.dmAddress;
  assign f3         = dm_bus.dmFunc3;
  assign wr_data_in = dm_bus.dmDataOut;
  assign widx       = addr[ADDR_BITS-1:2];

  // Region decode and access legality; only mapped regions can raise an error.
  always_comb begin : decode
    is_ram   = addr[31:ADDR_BITS] == '0;
    is_io    = addr[31:4] == IO_BASE[31:4];
    bad      = (is_ram || is_io) && (is_illegal(f3) || is_misaligned(f3, addr[1:0]));
    io_off   = {addr[3:2], 2'b00};
    ram_we   = dm_bus.dmWrite && is_ram && !bad;
    io_push  = dm_bus.dmWrite && is_io && !bad && (io_off == OFF_TXDATA);
    err_clr  = dm_bus.dmWrite && is_io && !bad && (io_off == OFF_STATUS) && wr_data_in[ST_ERR];
    err_d    = bad || (err_q && !err_clr);
    region_d = bad ? REG_NONE : (is_ram ? REG_RAM : (is_io ? REG_IO : REG_NONE));
  end

  always_comb begin : store_lanes
    be    = 4'b0000;
    wdata = wr_data_in;
    case (f3[1:0])
      2'd0: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{wr_data_in[7:0]}};
      end
      2'd1: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wr_data_in[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // Synchronous read of the old word, so a same-cycle store is seen only afterwards.
  always_ff @(posedge clock) begin : ram_port
    ram_rd_q <= ram[widx];
    for (int i = 0; i < 4; i++) begin
      if (ram_we && be[i]) ram[widx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clock or posedge reset) begin : cycle_counter
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_q + 32'd1;
  end
`endif

  always_comb begin : io_read
    occ4                          = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);
    status                        = '0;
    status[ST_NOT_FULL]           = !fifo_full;
    status[ST_EMPTY]              = fifo_empty;
    status[ST_COUNT_LSB +: 4]     = occ4;
    status[ST_ERR]                = err_q;
    io_rdata_d                    = '0;
    case (io_off)
      OFF_STATUS: io_rdata_d = status;
`ifdef DMEM_CYCLE_COUNTER_EN
      OFF_CYCLES: io_rdata_d = cyc_q;
`endif
      default:    io_rdata_d = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin : rd_ctrl
    if (reset) begin
      region_q   <= REG_NONE;
      f3_q       <= '0;
      lo_q       <= '0;
      io_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      region_q   <= region_d;
      f3_q       <= f3;
      lo_q       <= addr[1:0];
      io_rdata_q <= io_rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin : load_out
    load_data_c = '0;
    case (region_q)
      REG_RAM: load_data_c = load_format(ram_rd_q, f3_q, lo_q);
      REG_IO:  load_data_c = io_rdata_q;
      default: load_data_c = '0;
    endcase
  end

  assign dm_bus.dmDataIn = load_data_c;
  assign access_err      = err_q;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (io_push),
    .push_data_i (wr_data_in[7:0]),
    .ready_i     (tx_ready),
    .head_o      (tx_data),
    .valid_o     (tx_valid),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

endmodule
